hdmi_sync_gen: RTL

- Video timing generator that sits directly upstream of the frame-buffer reader in the HDMI path.
- Produces registered h_sync/v_sync/de plus pixel coordinates and a frame-start pulse. The frame-buffer reader consumes these, delays them through its own pipeline, and uses o_x bit 0 for 4:2:2 pixel pairing.
- Supports clean start and stop on frame boundaries, so the frame-buffer reader never sees a partial frame.

---
 rtl/hdmi_sync_gen_pkg.sv | 35 +++
 rtl/hdmi_sync_gen.sv | 98 +++++++++
 2 files changed

// File: rtl/hdmi_sync_gen_pkg.sv
// rtl/hdmi_sync_gen_pkg.sv - state encoding and register set for the video timing generator
package hdmi_sync_gen_pkg;

   typedef enum logic [1:0] {
      STATE_Idle     = 2'h0,
      STATE_Run      = 2'h1,
      STATE_Stopping = 2'h2
   } state_t;

   // hs/vs hold the "sync asserted" sense; pin polarity is applied at the outputs
   typedef struct packed {
      state_t      state;
      logic [11:0] h_cnt;
      logic [11:0] v_cnt;
      logic        hs;
      logic        vs;
      logic        de;
      logic [10:0] x;
      logic [9:0]  y;
      logic        frame_start;
   } hdmi_sync_gen_registers;

   localparam hdmi_sync_gen_registers hdmi_sync_gen_r_reset = '{
      state:       STATE_Idle,
      h_cnt:       12'd0,
      v_cnt:       12'd0,
      hs:          1'b0,
      vs:          1'b0,
      de:          1'b0,
      x:           11'd0,
      y:           10'd0,
      frame_start: 1'b0
   };

endpackage

// File: rtl/hdmi_sync_gen.sv
// rtl/hdmi_sync_gen.sv - video timing generator with frame-aligned start/stop
module hdmi_sync_gen
   import hdmi_sync_gen_pkg::*;
#(
   parameter int H_ACTIVE  = 1024,
   parameter int H_FRONT   = 40,
   parameter int H_SYNC    = 128,
   parameter int H_BACK    = 88,
   parameter int V_ACTIVE  = 600,
   parameter int V_FRONT   = 1,
   parameter int V_SYNC    = 4,
   parameter int V_BACK    = 23,
   parameter int HSYNC_POL = 1,
   parameter int VSYNC_POL = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_en,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_de,
   output logic [10:0] o_x,
   output logic [9:0]  o_y,
   output logic        o_frame_start,
   output logic        o_busy
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   if (H_TOTAL > 4096 || V_TOTAL > 4096 || H_ACTIVE > 2048 || V_ACTIVE > 1024) begin : g_bad_timing
      $error("hdmi_sync_gen: timing parameters exceed counter range");
   end

   // 13-bit bounds so a sync pulse ending exactly at 4096 still compares correctly
   localparam logic [12:0] H_ACT   = 13'(H_ACTIVE);
   localparam logic [12:0] HS_BEG  = 13'(H_ACTIVE + H_FRONT);
   localparam logic [12:0] HS_END  = 13'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [12:0] V_ACT   = 13'(V_ACTIVE);
   localparam logic [12:0] VS_BEG  = 13'(V_ACTIVE + V_FRONT);
   localparam logic [12:0] VS_END  = 13'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);

   hdmi_sync_gen_registers r, rin;
   logic [12:0] h13, v13;
   logic        h_wrap, frame_end, active;

   assign h13 = {1'b0, r.h_cnt};
   assign v13 = {1'b0, r.v_cnt};

   always_comb begin
      rin       = r;
      h_wrap    = (r.h_cnt == H_LAST);
      frame_end = h_wrap && (r.v_cnt == V_LAST);
      active    = (h13 < H_ACT) && (v13 < V_ACT);
      if (r.state == STATE_Idle) begin
         rin = hdmi_sync_gen_r_reset;
         if (i_en)
            rin.state = STATE_Run;
      end else begin
         rin.de          = active;
         rin.hs          = (h13 >= HS_BEG) && (h13 < HS_END);
         rin.vs          = (v13 >= VS_BEG) && (v13 < VS_END);
         rin.x           = active ? r.h_cnt[10:0] : 11'd0;
         rin.y           = active ? r.v_cnt[9:0] : 10'd0;
         rin.frame_start = (r.h_cnt == 12'd0) && (r.v_cnt == 12'd0);
         rin.h_cnt       = h_wrap ? 12'd0 : r.h_cnt + 12'd1;
         if (h_wrap)
            rin.v_cnt = (r.v_cnt == V_LAST) ? 12'd0 : r.v_cnt + 12'd1;
         // leaving RUN always passes through STOPPING so a stop lands on a frame end
         if (r.state == STATE_Run) begin
            if (!i_en)
               rin.state = STATE_Stopping;
         end else if (i_en) begin
            rin.state = STATE_Run;
         end else if (frame_end) begin
            rin.state = STATE_Idle;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r <= hdmi_sync_gen_r_reset;
      else
         r <= rin;
   end

   assign o_hsync       = (HSYNC_POL != 0) ? r.hs : ~r.hs;
   assign o_vsync       = (VSYNC_POL != 0) ? r.vs : ~r.vs;
   assign o_de          = r.de;
   assign o_x           = r.x;
   assign o_y           = r.y;
   assign o_frame_start = r.frame_start;
   assign o_busy        = (r.state != STATE_Idle);

endmodule
